// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM:
// opcodes, function codes, state/class enums and select encodings.
package multicycle_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd15;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_JMP   = 4'd9;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_HLT = 6'd28;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_IMM,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_HALT,
        CL_NOP
    } inst_class_t;

endpackage

// File: rtl/mc_inst_class.sv
// Instruction classifier: maps opcode/func to an instruction class.
// Ports: opcode[3:0], func[5:0] in; cls (inst_class_t) out.
module mc_inst_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [5:0]  func,
    output inst_class_t cls
);

    always_comb begin
        cls = CL_NOP;
        case (opcode)
            OP_RTYPE: cls = (func == FN_HLT) ? CL_HALT : CL_ALU;
            OP_ADI,
            OP_LHI:   cls = CL_IMM;
            OP_LWD:   cls = CL_LOAD;
            OP_SWD:   cls = CL_STORE;
            OP_BNE,
            OP_BEQ:   cls = CL_BRANCH;
            OP_JMP:   cls = CL_JUMP;
            default:  cls = CL_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle 16-bit CPU (IF/ID/EX/MEM/WB/HALT).
// Ports: clk, reset_n, opcode, func, bcond, mem_ack in; memory, PC, ALU,
// register-file controls, halted and inst_retired counter out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func,
    input  logic             bcond,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             wb_sel,
    output logic             halted,
    output logic [CNT_W-1:0] inst_retired
);

    state_t      state;
    state_t      state_nxt;
    inst_class_t cls;
    logic        retire;

    mc_inst_class u_cls (
        .opcode (opcode),
        .func   (func),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_retired <= '0;
        end else if (retire) begin
            inst_retired <= inst_retired + CNT_W'(1);
        end
    end

    // Outputs are gated by reset_n so an in-flight request drops
    // asynchronously, without waiting for a clock edge.
    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_INC;
        alu_op       = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RT;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        if (reset_n) begin
            case (state)
                S_IF: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_ONE;
                    if (mem_ack) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_INC;
                        state_nxt = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b = SRCB_SEXT;
                    case (cls)
                        CL_HALT: state_nxt = S_HALT;
                        CL_NOP: begin
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end
                        default: state_nxt = S_EX;
                    endcase
                end
                S_EX: begin
                    case (cls)
                        CL_ALU: begin
                            alu_op    = 1'b1;
                            alu_src_a = 1'b1;
                            alu_src_b = SRCB_RT;
                            state_nxt = S_WB;
                        end
                        CL_IMM: begin
                            alu_op    = 1'b1;
                            alu_src_a = 1'b1;
                            alu_src_b = (opcode == OP_LHI) ? SRCB_ZEXT : SRCB_SEXT;
                            state_nxt = S_WB;
                        end
                        CL_LOAD,
                        CL_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRCB_SEXT;
                            state_nxt = S_MEM;
                        end
                        CL_BRANCH: begin
                            alu_op    = 1'b1;
                            alu_src_a = 1'b1;
                            alu_src_b = SRCB_RT;
                            pc_write  = bcond;
                            pc_src    = PC_SRC_BR;
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end
                        CL_JUMP: begin
                            pc_write  = 1'b1;
                            pc_src    = PC_SRC_JMP;
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end
                        default: state_nxt = S_IF;
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_SWD);
                    if (mem_ack) begin
                        if (cls == CL_STORE) begin
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (cls == CL_ALU);
                    wb_sel    = (cls == CL_LOAD);
                    retire    = 1'b1;
                    state_nxt = S_IF;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_nxt = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors
// are queued per instruction and compared as the FSM steps through them.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        bcond;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic        reg_dst;
    logic        wb_sel;
    logic        halted;
    logic [15:0] inst_retired;

    multicycle_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .func         (func),
        .bcond        (bcond),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .inst_retired (inst_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] exp;
        logic        ack;
        string       tag;
    } step_t;

    step_t       sb[$];
    int          vecs = 0;
    int          errs = 0;
    logic [15:0] ret_exp = '0;

    wire [14:0] obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                       pc_src, alu_op, alu_src_a, alu_src_b,
                       reg_write, reg_dst, wb_sel, halted};

    function automatic logic [14:0] mk(
        input logic       req, we, asel, irw, pcw,
        input logic [1:0] pcs,
        input logic       aop, sa,
        input logic [1:0] sbv,
        input logic       rw, rd, wb, h
    );
        return {req, we, asel, irw, pcw, pcs, aop, sa, sbv, rw, rd, wb, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        vecs++;
        assert (o === e) else begin
            errs++;
            $display("FAIL %s: observed %h expected %h", tag, o, e);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic push(input logic [14:0] e, input logic a, input string t);
        step_t s;
        s.exp = e;
        s.ack = a;
        s.tag = t;
        sb.push_back(s);
    endtask

    // Entered and left at posedge+1; one queued step per clock cycle.
    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            mem_ack = s.ack;
            @(negedge clk);
            chk(s.tag, {17'd0, obs}, {17'd0, s.exp});
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic run_inst(input logic [3:0] op, input logic [5:0] fn,
                            input logic bc, input int if_wait,
                            input int mem_wait, input string nm);
        opcode = op;
        func   = fn;
        bcond  = bc;
        for (int i = 0; i < if_wait; i++)
            push(mk(1,0,0,0,0,2'd0,0,0,2'd1,0,0,0,0), 1'b0, {nm, "_if_wait"});
        push(mk(1,0,0,1,1,2'd0,0,0,2'd1,0,0,0,0), 1'b1, {nm, "_if_ack"});
        push(mk(0,0,0,0,0,2'd0,0,0,2'd2,0,0,0,0), 1'b1, {nm, "_id"});
        if (op == 4'd15 && fn == 6'd28) begin
            for (int i = 0; i < 20; i++)
                push(mk(0,0,0,0,0,2'd0,0,0,2'd0,0,0,0,1), i[0], {nm, "_halt"});
            drain();
            chk({nm, "_retired"}, {16'd0, inst_retired}, {16'd0, ret_exp});
            return;
        end
        case (op)
            4'd15: begin
                push(mk(0,0,0,0,0,2'd0,1,1,2'd0,0,0,0,0), 1'b0, {nm, "_ex"});
                push(mk(0,0,0,0,0,2'd0,0,0,2'd0,1,1,0,0), 1'b0, {nm, "_wb"});
            end
            4'd4, 4'd6: begin
                push(mk(0,0,0,0,0,2'd0,1,1,(op == 4'd6) ? 2'd3 : 2'd2,0,0,0,0),
                     1'b0, {nm, "_ex"});
                push(mk(0,0,0,0,0,2'd0,0,0,2'd0,1,0,0,0), 1'b0, {nm, "_wb"});
            end
            4'd7, 4'd8: begin
                push(mk(0,0,0,0,0,2'd0,0,1,2'd2,0,0,0,0), 1'b0, {nm, "_ex"});
                for (int i = 0; i < mem_wait; i++)
                    push(mk(1,op == 4'd8,1,0,0,2'd0,0,0,2'd0,0,0,0,0),
                         1'b0, {nm, "_mem_wait"});
                push(mk(1,op == 4'd8,1,0,0,2'd0,0,0,2'd0,0,0,0,0),
                     1'b1, {nm, "_mem_ack"});
                if (op == 4'd7)
                    push(mk(0,0,0,0,0,2'd0,0,0,2'd0,1,0,1,0), 1'b0, {nm, "_wb"});
            end
            4'd0, 4'd1:
                push(mk(0,0,0,0,bc,2'd1,1,1,2'd0,0,0,0,0), 1'b0, {nm, "_ex"});
            4'd9:
                push(mk(0,0,0,0,1,2'd2,0,0,2'd0,0,0,0,0), 1'b0, {nm, "_ex"});
            default: ;
        endcase
        drain();
        ret_exp = ret_exp + 16'd1;
        chk({nm, "_retired"}, {16'd0, inst_retired}, {16'd0, ret_exp});
    endtask

    task automatic reset_pulse(input string nm);
        reset_n = 1'b0;
        mem_ack = 1'b0;
        #1;
        ret_exp = '0;
        chk({nm, "_outs"}, {17'd0, obs}, 32'd0);
        chk({nm, "_retired"}, {16'd0, inst_retired}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        mem_ack = 1'b0;
        opcode  = 4'd0;
        func    = 6'd0;
        bcond   = 1'b0;
        #12;
        chk("reset_outs", {17'd0, obs}, 32'd0);
        chk("reset_retired", {16'd0, inst_retired}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_inst(4'd15, 6'd0,  1'b0, 0, 0, "add");
        run_inst(4'd15, 6'd0,  1'b0, 2, 0, "add_ifwait");
        run_inst(4'd7,  6'd0,  1'b0, 0, 3, "lwd_wait3");
        run_inst(4'd8,  6'd0,  1'b0, 0, 0, "swd");
        run_inst(4'd8,  6'd0,  1'b0, 1, 2, "swd_wait");
        run_inst(4'd1,  6'd0,  1'b1, 0, 0, "beq_taken");
        run_inst(4'd1,  6'd0,  1'b0, 0, 0, "beq_not");
        run_inst(4'd0,  6'd0,  1'b1, 0, 0, "bne_taken");
        run_inst(4'd9,  6'd0,  1'b0, 0, 0, "jmp");
        run_inst(4'd4,  6'd0,  1'b0, 0, 0, "adi");
        run_inst(4'd6,  6'd0,  1'b0, 1, 0, "lhi");
        run_inst(4'd2,  6'd0,  1'b0, 0, 0, "nop2");
        run_inst(4'd13, 6'd0,  1'b0, 1, 0, "nop13");
        run_inst(4'd15, 6'd5,  1'b0, 0, 0, "rtype_fn5");
        run_inst(4'd7,  6'd0,  1'b0, 0, 0, "lwd");

        run_inst(4'd15, 6'd28, 1'b0, 0, 0, "hlt");
        reset_pulse("halt_reset");
        run_inst(4'd15, 6'd0,  1'b0, 0, 0, "add_after_halt");

        opcode = 4'd15;
        func   = 6'd0;
        push(mk(1,0,0,0,0,2'd0,0,0,2'd1,0,0,0,0), 1'b0, "ifwait_pre_reset");
        push(mk(1,0,0,0,0,2'd0,0,0,2'd1,0,0,0,0), 1'b0, "ifwait_pre_reset");
        drain();
        reset_pulse("ifwait_reset");
        run_inst(4'd15, 6'd0,  1'b0, 1, 0, "add_after_reset");
        run_inst(4'd8,  6'd0,  1'b0, 0, 1, "swd_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle variant of the 16-bit CPU.
- Sequences a shared datapath through fetch, decode, execute, memory and writeback: one ALU, one unified memory port, and the register file.
- Drives the 1-bit ALUOp input of the ALU control decoder.
  - 0 forces ADD, used for PC increment, branch target and address calculation.
  - 1 selects the opcode/function decode.
- Handshakes with memory via req/ack and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  4  IR[15:12], valid from ID onward
- func  in  6  IR[5:0], function code for opcode 15
- bcond  in  1  ALU compare result, valid in EX
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  latch fetched word into IR
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+1, 1 = branch target (ALUOut), 2 = jump target
- alu_op  out  1  ALUOp to the ALU control decoder
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 1, 2 = sign-extended imm, 3 = zero-extended imm
- reg_write  out  1  register file write strobe
- reg_dst  out  1  0 = rt, 1 = rd
- wb_sel  out  1  0 = ALUOut, 1 = MDR
- halted  out  1  sticky halt indicator
- inst_retired  out  CNT_W  retired-instruction counter

Behaviour:
- Reset (async, reset_n low):
  - State goes to IF, inst_retired = 0, halted = 0.
  - All strobes are 0: mem_req, mem_we, ir_write, pc_write, reg_write.
  - All selects are 0.
- Reset mid-access drops mem_req immediately; the pending ack is ignored.
- Opcodes:
  - 15 = R-type (func 0 ADD, func 28 HLT, other funcs treated as ALU ops)
  - 4 = ADI, 6 = LHI, 7 = LWD, 8 = SWD, 0 = BNE, 1 = BEQ, 9 = JMP
  - Any other opcode is a NOP.
- Outputs are Moore-decoded from state; strobes are qualified by mem_ack where noted.
- IF:
  - mem_req = 1, mem_addr_sel = 0, alu_op = 0, alu_src_a = 0, alu_src_b = 1.
  - Wait while mem_ack = 0.
  - On the ack cycle: ir_write = 1, pc_write = 1, pc_src = 0, then go to ID.
- ID (1 cycle):
  - alu_op = 0, alu_src_a = 0, alu_src_b = 2: branch target PC+1+imm is computed into ALUOut.
  - HLT goes to HALT.
  - NOP retires and goes to IF.
  - All other opcodes go to EX.
- EX (1 cycle):
  - R-type: alu_op = 1, alu_src_a = 1, alu_src_b = 0; go to WB.
  - ADI / LHI: alu_op = 1, alu_src_a = 1, alu_src_b = 2 for ADI, 3 for LHI; go to WB.
  - LWD / SWD: alu_op = 0, alu_src_a = 1, alu_src_b = 2; go to MEM.
  - BEQ / BNE: alu_op = 1, alu_src_a = 1, alu_src_b = 0; pc_write = bcond, pc_src = 1; retire; go to IF.
  - JMP: pc_write = 1, pc_src = 2; retire; go to IF.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = (opcode == 8).
  - Address and we stay stable until ack.
  - On ack: SWD retires and goes to IF; LWD goes to WB.
- WB (1 cycle):
  - reg_write = 1.
  - reg_dst = 1 for R-type, else 0.
  - wb_sel = 1 for LWD, else 0.
  - Retire; go to IF.
- HALT:
  - halted = 1, all strobes 0, mem_req = 0.
  - Leaves only on reset.
  - HLT itself is not counted.
- Retire: inst_retired += 1 on the clock edge leaving the final state; wraps from 2^CNT_W-1 to 0.
- mem_ack while mem_req = 0 is ignored.
- Latency with zero-wait memory (ack in the first request cycle):
  - R / ADI / LHI: 4 cycles
  - LWD: 5 cycles
  - SWD: 4 cycles
  - branch / JMP: 3 cycles
  - NOP: 2 cycles
- Each memory wait cycle adds 1.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE = 15, OP_ADI = 4, OP_LHI = 6, OP_LWD = 7, OP_SWD = 8, OP_BNE = 0, OP_BEQ = 1, OP_JMP = 9)
  - function constants (FN_ADD = 0, FN_HLT = 28)
  - state enum (IF, ID, EX, MEM, WB, HALT)
  - pc_src and alu_src_b encodings
- One combinational sub-module, mc_inst_class, maps opcode/func to the class {ALU, IMM, LOAD, STORE, BRANCH, JUMP, HALT, NOP}.

Test Plan:
- ADD (opcode 15, func 0), mem_ack in first IF cycle:
  - States IF, ID, EX, WB; reg_write = 1 only in cycle 4, reg_dst = 1.
  - inst_retired goes 0 -> 1.
- LWD, mem_ack delayed 3 cycles in MEM:
  - mem_req high 4 cycles with mem_addr_sel = 1, mem_we = 0.
  - Then WB with wb_sel = 1; total 8 cycles.
- SWD, ack immediate:
  - mem_we = 1 during MEM, reg_write never asserted.
  - Retire after 4 cycles.
- BEQ with bcond = 1, then BEQ with bcond = 0:
  - First case: pc_write = 1, pc_src = 1 in EX.
  - Second case: pc_write = 0 in EX.
  - Both retire in 3 cycles.
- HLT (opcode 15, func 28):
  - halted = 1 after ID; mem_req stays 0 for 20 cycles; inst_retired unchanged.
  - reset_n pulse returns the FSM to IF with halted = 0.
- reset_n low during IF wait with mem_req = 1:
  - mem_req falls without a clock edge; inst_retired = 0.
  - After release, fetch restarts.
